// File: rtl/lsu_dmem_master.sv
// RV32 load/store initiator for a word-addressed, byte-enabled synchronous data memory (1-cycle read latency).
// Optional feature: define LSU_RANGE_CHECK_EN to flag accesses whose upper address bits exceed the memory size.
`timescale 1ns/1ps
module lsu_dmem_master #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int BYTES         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [BYTES-1:0]         mem_be,
    output logic [31:0]              mem_wdata,
    output logic                     mem_we,
    input  logic [31:0]              mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_RD,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic [1:0]  off;
    logic        legal_f3;
    logic        aligned;
    logic        in_range;
    logic        req_err;
    logic        accept;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_lane;
    logic [31:0] load_data;

    assign off    = req_addr[1:0];
    assign accept = req_valid & req_ready;

`ifdef LSU_RANGE_CHECK_EN
    assign in_range = (req_addr[31:ADDRESS_WIDTH+2] == '0);
`else
    // Upper address bits alias modulo the memory size.
    logic unused_upper_addr;
    assign unused_upper_addr = ^req_addr[31:ADDRESS_WIDTH+2];
    assign in_range = 1'b1;
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        legal_f3 = 1'b0;
        aligned  = 1'b0;
        case (req_funct3)
            3'b000:  begin legal_f3 = 1'b1;    aligned = 1'b1;        end
            3'b001:  begin legal_f3 = 1'b1;    aligned = ~off[0];     end
            3'b010:  begin legal_f3 = 1'b1;    aligned = (off == 2'b00); end
            3'b100:  begin legal_f3 = ~req_we; aligned = 1'b1;        end
            3'b101:  begin legal_f3 = ~req_we; aligned = ~off[0];     end
            default: begin legal_f3 = 1'b0;    aligned = 1'b0;        end
        endcase
        req_err = ~legal_f3 | ~aligned | ~in_range;
    end

    // Store lanes: narrow data is replicated so the byte enables pick the lane.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << off;
                store_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_be    = off[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
            3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
            3'b100:  load_data = {24'b0, load_lane[7:0]};
            3'b101:  load_data = {16'b0, load_lane[15:0]};
            default: load_data = load_lane;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        off_q     <= off;
                        f3_q      <= req_funct3;
                        we_q      <= req_we;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_addr  <= req_addr[ADDRESS_WIDTH+1:2];
                            mem_be    <= req_we ? store_be : 4'b1111;
                            mem_wdata <= req_we ? store_wdata : 32'b0;
                            mem_we    <= req_we;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    state  <= WAIT_RD;
                end
                WAIT_RD: begin
                    resp_rdata <= we_q ? 32'b0 : load_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master: directed scenarios plus randomized traffic against a byte-level memory model.
`timescale 1ns/1ps
module tb_lsu_dmem_master;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem     [DEPTH];
    logic [31:0]   ref_mem [DEPTH];

    int            checks;
    int            passed;
    int            we_count = 0;
    logic [AW-1:0] we_addr;
    logic [3:0]    we_be;
    logic [31:0]   we_data;
    time           acc_t;

    lsu_dmem_master #(.ADDRESS_WIDTH(AW), .BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-enabled synchronous memory, registered read of the old contents.
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_count = we_count + 1;
            we_addr  = mem_addr;
            we_be    = mem_be;
            we_data  = mem_wdata;
        end
    end

    // Reference: RV32 load/store rules applied to a word array by byte arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int size, off, word;
        logic legal;
        logic [31:0] v, mask;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << int'(f3[1:0]);
        off   = int'(addr % 4);
        word  = int'((addr / 4) % DEPTH);
        err   = !legal || ((off % size) != 0);
`ifdef LSU_RANGE_CHECK_EN
        if ((addr / (4 * DEPTH)) != 0) err = 1'b1;
`endif
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[word][8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                v = ref_mem[word] >> (8 * off);
                if (size == 4) rd = v;
                else begin
                    mask = (32'd1 << (8 * size)) - 32'd1;
                    rd   = v & mask;
                    if (!f3[2] && rd[8*size-1]) rd = rd | ~mask;
                end
            end
        end
    endfunction

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        acc_t = $time;
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (resp_valid !== 1'b1) lat = -1;
        rd = resp_rdata;
        er = resp_err;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h12345678;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_be, mem_wdata, mem_we} !== '0)
            $display("FAIL reset_outputs: rdy=%b rv=%b err=%b rd=%h ma=%h be=%b wd=%h we=%b, want all zero",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_be, mem_wdata, mem_we);
        else passed++;
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || we_count != 0)
            $display("FAIL post_reset: req_ready=%b resp_valid=%b writes=%0d, want 1 0 0", req_ready, resp_valid, we_count);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, w0, t;
        w0 = we_count;
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, mer, mrd);
        checks++;
        if (er !== mer || rd !== mrd || lat != 3)
            $display("FAIL sw_resp: err=%b rd=%h lat=%0d, want %b %h 3", er, rd, lat, mer, mrd);
        else passed++;
        checks++;
        if (we_count - w0 != 1 || we_addr !== 9'd4 || we_be !== 4'b1111 || we_data !== 32'hDEADBEEF)
            $display("FAIL sw_mem_cycle: writes=%0d addr=%0d be=%b data=%h, want 1 4 1111 deadbeef",
                     we_count - w0, we_addr, we_be, we_data);
        else passed++;
        checks++;
        if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_word4: got %h want deadbeef", mem[4]);
        else passed++;

        w0 = we_count;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1) $display("FAIL access_we: mem_we=%b want 1", mem_we);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) $display("FAIL async_drop: mem_we=%b want 0", mem_we);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        repeat (6) begin @(negedge clk); if (resp_valid !== 1'b0) t++; end
        checks++;
        if (t != 0 || we_count != w0 || mem[4] !== 32'hDEADBEEF)
            $display("FAIL abort: resp_cycles=%0d writes=%0d word4=%h, want 0 0 deadbeef", t, we_count - w0, mem[4]);
        else passed++;
    endtask

    task automatic test_byte_loads();
        logic [2:0]  f3 [3] = '{3'b000, 3'b100, 3'b000};
        logic [31:0] ad [3] = '{32'h13, 32'h13, 32'h10};
        logic [31:0] ex [3] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFFFBB};
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        xact(1'b1, 3'b010, 32'h10, 32'h8899AABB, 0, rd, er, lat);
        model(1'b1, 3'b010, 32'h10, 32'h8899AABB, mer, mrd);
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, f3[i], ad[i], $urandom, 0, rd, er, lat);
            model(1'b0, f3[i], ad[i], 32'd0, mer, mrd);
            checks++;
            if (rd !== ex[i] || er !== 1'b0 || lat != 3)
                $display("FAIL byte_load[%0d]: rd=%h err=%b lat=%0d, want %h 0 3", i, rd, er, lat, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_half_loads();
        logic [2:0]  f3 [3] = '{3'b001, 3'b101, 3'b010};
        logic [31:0] ad [3] = '{32'h12, 32'h10, 32'h10};
        logic [31:0] ex [3] = '{32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, f3[i], ad[i], $urandom, 0, rd, er, lat);
            model(1'b0, f3[i], ad[i], 32'd0, mer, mrd);
            checks++;
            if (rd !== ex[i] || er !== 1'b0 || lat != 3)
                $display("FAIL half_load[%0d]: rd=%h err=%b lat=%0d, want %h 0 3", i, rd, er, lat, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_partial_stores();
        logic [2:0]  f3 [2] = '{3'b000, 3'b001};
        logic [31:0] ad [2] = '{32'h11, 32'h12};
        logic [31:0] wd [2] = '{32'hFFFFFF55, 32'hABCD1234};
        logic [3:0]  eb [2] = '{4'b0010, 4'b1100};
        logic [31:0] ew [2] = '{32'h55555555, 32'h12341234};
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, w0;
        for (int i = 0; i < 2; i++) begin
            w0 = we_count;
            xact(1'b1, f3[i], ad[i], wd[i], 0, rd, er, lat);
            model(1'b1, f3[i], ad[i], wd[i], mer, mrd);
            checks++;
            if (we_count - w0 != 1 || we_be !== eb[i] || we_data !== ew[i] || er !== 1'b0 || lat != 3)
                $display("FAIL part_store[%0d]: writes=%0d be=%b data=%h err=%b lat=%0d, want 1 %b %h 0 3",
                         i, we_count - w0, we_be, we_data, er, lat, eb[i], ew[i]);
            else passed++;
        end
        xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        model(1'b0, 3'b010, 32'h10, 32'd0, mer, mrd);
        checks++;
        if (rd !== 32'h123455BB) $display("FAIL part_readback: got %h want 123455bb", rd);
        else passed++;
    endtask

    task automatic test_errors();
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] ad [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
        logic [31:0] rd, mrd, snap;
        logic er, mer;
        int lat, w0;
        snap = mem[4];
        w0 = we_count;
        for (int i = 0; i < 4; i++) begin
            xact(we[i], f3[i], ad[i], $urandom, 0, rd, er, lat);
            model(we[i], f3[i], ad[i], 32'd0, mer, mrd);
            checks++;
            if (er !== 1'b1 || rd !== 32'd0 || lat != 1)
                $display("FAIL error_resp[%0d]: err=%b rd=%h lat=%0d, want 1 0 1", i, er, rd, lat);
            else passed++;
        end
        checks++;
        if (we_count != w0 || mem[4] !== snap)
            $display("FAIL error_no_write: writes=%0d word4=%h, want 0 %h", we_count - w0, mem[4], snap);
        else passed++;
    endtask

    task automatic test_backpressure_range();
        logic [31:0] rd, mrd, held;
        logic er, mer;
        int lat, t;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = $urandom;
        t = 0;
        while (resp_valid !== 1'b1 && t < 12) begin @(negedge clk); t++; end
        model(1'b0, 3'b010, 32'h10, 32'd0, mer, mrd);
        held = resp_rdata;
        checks++;
        if (resp_valid !== 1'b1 || held !== mrd)
            $display("FAIL bp_first: valid=%b rd=%h, want 1 %h", resp_valid, held, mrd);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: valid=%b rd=%h ready=%b, want 1 %h 0", c, resp_valid, resp_rdata, req_ready, held);
            else passed++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
        else passed++;

        xact(1'b1, 3'b010, 32'h0, 32'hC0FFEE11, 0, rd, er, lat);
        model(1'b1, 3'b010, 32'h0, 32'hC0FFEE11, mer, mrd);
        xact(1'b0, 3'b010, 32'h800, 32'd0, 0, rd, er, lat);
        model(1'b0, 3'b010, 32'h800, 32'd0, mer, mrd);
        checks++;
        if (er !== mer || rd !== mrd || lat != (mer ? 1 : 3))
            $display("FAIL range_0x800: err=%b rd=%h lat=%0d, want %b %h %0d", er, rd, lat, mer, mrd, mer ? 1 : 3);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic er;
        int lat;
        time prev;
        xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        for (int i = 0; i < 3; i++) begin
            prev = acc_t;
            xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
            checks++;
            if (acc_t - prev != 40) $display("FAIL throughput[%0d]: spacing=%0t want 40", i, acc_t - prev);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wd;
        logic er, mer, we;
        logic [2:0] f3;
        int lat, w0;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            xact(1'b1, 3'b010, 32'(w * 4), wd, 0, rd, er, lat);
            model(1'b1, 3'b010, 32'(w * 4), wd, mer, mrd);
        end
        for (int n = 0; n < 150; n++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom);
            wd   = $urandom;
            addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr + ($urandom << 11);
            w0 = we_count;
            xact(we, f3, addr, wd, $urandom_range(0, 2), rd, er, lat);
            model(we, f3, addr, wd, mer, mrd);
            checks++;
            if (er !== mer || rd !== mrd || lat != (mer ? 1 : 3) || we_count - w0 != ((we && !mer) ? 1 : 0))
                $display("FAIL random[%0d] we=%b f3=%b addr=%h: err=%b rd=%h lat=%0d writes=%0d, want %b %h %0d %0d",
                         n, we, f3, addr, er, rd, lat, we_count - w0, mer, mrd, mer ? 1 : 3, (we && !mer) ? 1 : 0);
            else passed++;
        end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (mem[w] !== ref_mem[w]) $display("FAIL final_word[%0d]: got %h want %h", w, mem[w], ref_mem[w]);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b0;
        test_reset();
        test_reset_mid_access();
        test_byte_loads();
        test_half_loads();
        test_partial_stores();
        test_errors();
        test_backpressure_range();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
